seg7_scan_ctrl: RTL

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: cycles through NUM_DIGITS digits,
// inserting an all-off dead time before each digit, with double-buffered
// display data that only changes at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit INVERT       = 1'b1,
  parameter bit AN_INVERT    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  // With no dead time the scan goes straight from one digit to the next.
  localparam logic [1:0] S_NEXT  = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{INVERT}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INVERT}};

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_valid;

  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] disp_shift;
  logic [NUM_DIGITS-1:0]   mask_shift;
  logic [NUM_DIGITS-1:0]   dp_shift;
  logic [NUM_DIGITS-1:0]   one_hot;
  logic [3:0]              nibble;
  logic [6:0]              pattern;

  // Current digit selection, frame-boundary detect and hex-to-segment decode.
  always_comb begin
    wrap       = en && (state == S_DRIVE) && (cnt == DRIVE_LAST) && (idx == LAST_IDX);
    disp_shift = disp >> {idx, 2'b00};
    mask_shift = blank_mask >> idx;
    dp_shift   = dp >> idx;
    one_hot    = NUM_DIGITS'(1) << idx;
    nibble     = disp_shift[3:0];
    pattern    = 7'h00;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
  end

  // Scan sequencer: dead time then drive time per digit, dropping to idle whenever disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_NEXT;
          idx   <= '0;
          cnt   <= '0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= S_DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state <= S_NEXT;
            cnt   <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Double buffer: loads park in pending and move to the display only at a frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        disp <= value;
      end else if (pend_valid) begin
        disp <= pend;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend       <= value;
      pend_valid <= 1'b1;
    end
  end

  // Registered outputs reflecting the sequencer state of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      dp_out     <= INVERT;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (state == S_DRIVE) begin
        an     <= one_hot ^ AN_OFF;
        dp_out <= dp_shift[0] ^ INVERT;
        seg    <= mask_shift[0] ? SEG_OFF : (pattern ^ SEG_OFF);
      end else begin
        an     <= AN_OFF;
        dp_out <= INVERT;
        seg    <= SEG_OFF;
      end
    end
  end

endmodule
